// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table checker.
package tt_pkg;

  localparam int unsigned DefaultN      = 2;
  localparam int unsigned DefaultSettle = 1;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StFin
  } tt_state_e;

  // Number of rows in an n-input truth table.
  function automatic int unsigned row_count(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Per-row settle counter: load a count, decrement while enabled, flag expiry at zero.
module tt_settle_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             expire_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps all 2**N input rows, comparing two gate implementations row by row.
// Optional macro TT_GOLDEN_EN adds a check of a_in against the OR of the stimulus.
module truth_table_checker
  import tt_pkg::*;
#(
  parameter int unsigned N      = DefaultN,
  parameter int unsigned SETTLE = DefaultSettle
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   a_in,
  input  logic                   b_in,
  output logic [N-1:0]           stim,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [row_count(N)-1:0] err_vec,
  output logic [N:0]             err_cnt
);

  localparam int unsigned Rows       = row_count(N);
  localparam logic [N:0]  CntMax     = (N+1)'(Rows);
  localparam logic [3:0]  SettleLoad = 4'(SETTLE - 1);

  tt_state_e         state_q, state_d;
  logic [N-1:0]      stim_q, stim_d;
  logic [Rows-1:0]   err_vec_q, err_vec_d;
  logic [N:0]        err_cnt_q, err_cnt_d;
  logic              pass_q, pass_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timer_load;
  logic              timer_expire;
  logic              row_bad;

`ifdef TT_GOLDEN_EN
  assign row_bad = (a_in != b_in) || (a_in != (|stim_q));
`else
  assign row_bad = (a_in != b_in);
`endif

  tt_settle_timer #(
    .Width (4)
  ) u_settle_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (timer_load),
    .load_val_i (SettleLoad),
    .en_i       (state_q == StDrive),
    .expire_o   (timer_expire)
  );

  always_comb begin
    state_d    = state_q;
    stim_d     = stim_q;
    err_vec_d  = err_vec_q;
    err_cnt_d  = err_cnt_q;
    pass_d     = pass_q;
    timer_load = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StDrive;
          stim_d     = '0;
          err_vec_d  = '0;
          err_cnt_d  = '0;
          pass_d     = 1'b0;
          timer_load = 1'b1;
        end
      end
      StDrive: begin
        if (timer_expire) begin
          state_d = StSample;
        end
      end
      StSample: begin
        if (row_bad) begin
          err_vec_d[stim_q] = 1'b1;
          if (err_cnt_q != CntMax) begin
            err_cnt_d = err_cnt_q + (N+1)'(1);
          end
        end
        // Last row reached: finish instead of wrapping the stimulus.
        if (&stim_q) begin
          state_d = StFin;
          pass_d  = (err_cnt_d == '0);
        end else begin
          state_d    = StDrive;
          stim_d     = stim_q + N'(1);
          timer_load = 1'b1;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StDrive) || (state_d == StSample);
    done_d = (state_d == StFin);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      stim_q    <= '0;
      err_vec_q <= '0;
      err_cnt_q <= '0;
      pass_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      stim_q    <= stim_d;
      err_vec_q <= err_vec_d;
      err_cnt_q <= err_cnt_d;
      pass_q    <= pass_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign stim    = stim_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_vec = err_vec_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: two instances (SETTLE=1 and SETTLE=3).
module tb_truth_table_checker;

  logic       clk;
  logic       rst;
  logic       start1, start2;
  logic       a1, b1, a2, b2;
  logic [1:0] stim1, stim2;
  logic       busy1, busy2, done1, done2, pass1, pass2;
  logic [3:0] err_vec1, err_vec2;
  logic [2:0] err_cnt1, err_cnt2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int mode     = 0;  // 0: a=b=OR, 1: b forced low on row 10, 2: a=b=AND

  truth_table_checker #(
    .N      (2),
    .SETTLE (1)
  ) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .start   (start1),
    .a_in    (a1),
    .b_in    (b1),
    .stim    (stim1),
    .busy    (busy1),
    .done    (done1),
    .pass    (pass1),
    .err_vec (err_vec1),
    .err_cnt (err_cnt1)
  );

  truth_table_checker #(
    .N      (2),
    .SETTLE (3)
  ) u_dut3 (
    .clk     (clk),
    .rst     (rst),
    .start   (start2),
    .a_in    (a2),
    .b_in    (b2),
    .stim    (stim2),
    .busy    (busy2),
    .done    (done2),
    .pass    (pass2),
    .err_vec (err_vec2),
    .err_cnt (err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    a1 = (mode == 2) ? (&stim1) : (|stim1);
    b1 = (mode == 1 && stim1 == 2'b10) ? 1'b0 : a1;
    a2 = |stim2;
    b2 = a2;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one sweep on the selected instance, observing 40 cycles after start.
  task automatic sweep(input int sel, input int settle, input bit restart,
                       output int done_at, output int n_done,
                       output int busy_cycles, output int stim_bad);
    logic       b, d;
    logic [1:0] s;
    done_at = -1; n_done = 0; busy_cycles = 0; stim_bad = 0;
    if (sel == 0) start1 = 1'b1; else start2 = 1'b1;
    step();
    start1 = 1'b0; start2 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      b = (sel == 0) ? busy1 : busy2;
      d = (sel == 0) ? done1 : done2;
      s = (sel == 0) ? stim1 : stim2;
      if (b) begin
        if (int'(s) != busy_cycles / (settle + 1)) stim_bad++;
        busy_cycles++;
      end
      if (d) begin
        if (n_done == 0) done_at = k;
        n_done++;
      end
      if (restart && k == 3) start1 = 1'b1;
      if (restart && k == 5) start1 = 1'b0;
      step();
    end
  endtask

  int done_at, n_done, busy_cycles, stim_bad;
  int waited;

  initial begin
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
    step(); step();
    check_eq("rst_stim", 32'(stim1), 32'd0);
    check_eq("rst_busy", 32'(busy1), 32'd0);
    check_eq("rst_done", 32'(done1), 32'd0);
    check_eq("rst_pass", 32'(pass1), 32'd0);
    check_eq("rst_err_vec", 32'(err_vec1), 32'd0);
    check_eq("rst_err_cnt", 32'(err_cnt1), 32'd0);

    // Reset wins over a simultaneous start.
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    check_eq("rst_over_start_busy", 32'(busy1), 32'd0);
    rst = 1'b0;
    step();

    // Clean sweep, OR gates agree.
    mode = 0;
    sweep(0, 1, 1'b0, done_at, n_done, busy_cycles, stim_bad);
    check_eq("or_done_at", done_at, 9);
    check_eq("or_n_done", n_done, 1);
    check_eq("or_busy_cycles", busy_cycles, 8);
    check_eq("or_stim_seq", stim_bad, 0);
    check_eq("or_pass", 32'(pass1), 32'd1);
    check_eq("or_err_vec", 32'(err_vec1), 32'h0);
    check_eq("or_err_cnt", 32'(err_cnt1), 32'd0);
    check_eq("or_stim_end", 32'(stim1), 32'd3);

    // b_in stuck low on row 10.
    mode = 1;
    sweep(0, 1, 1'b0, done_at, n_done, busy_cycles, stim_bad);
    check_eq("row2_done_at", done_at, 9);
    check_eq("row2_pass", 32'(pass1), 32'd0);
    check_eq("row2_err_vec", 32'(err_vec1), 32'h4);
    check_eq("row2_err_cnt", 32'(err_cnt1), 32'd1);

    // Start re-asserted while busy is ignored; next accepted start clears results.
    mode = 0;
    sweep(0, 1, 1'b1, done_at, n_done, busy_cycles, stim_bad);
    check_eq("restart_n_done", n_done, 1);
    check_eq("restart_done_at", done_at, 9);
    check_eq("restart_busy_cycles", busy_cycles, 8);
    check_eq("restart_stim_seq", stim_bad, 0);
    check_eq("restart_pass", 32'(pass1), 32'd1);
    check_eq("restart_err_vec", 32'(err_vec1), 32'h0);

    // Reset in the middle of a sweep while stim = 01.
    mode = 1;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    waited = 0;
    while (!(busy1 && stim1 == 2'b01) && waited < 20) begin
      step();
      waited++;
    end
    check_eq("midrst_reached_row1", 32'(waited < 20), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("midrst_stim", 32'(stim1), 32'd0);
    check_eq("midrst_busy", 32'(busy1), 32'd0);
    check_eq("midrst_done", 32'(done1), 32'd0);
    check_eq("midrst_err_cnt", 32'(err_cnt1), 32'd0);
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      if (done1 || busy1) n_done++;
      step();
    end
    check_eq("midrst_quiet", n_done, 0);
    mode = 0;
    sweep(0, 1, 1'b0, done_at, n_done, busy_cycles, stim_bad);
    check_eq("post_rst_done_at", done_at, 9);
    check_eq("post_rst_pass", 32'(pass1), 32'd1);

    // AND gates: only the golden OR check can see a difference.
    mode = 2;
    sweep(0, 1, 1'b0, done_at, n_done, busy_cycles, stim_bad);
`ifdef TT_GOLDEN_EN
    check_eq("and_err_vec", 32'(err_vec1), 32'h6);
    check_eq("and_err_cnt", 32'(err_cnt1), 32'd2);
    check_eq("and_pass", 32'(pass1), 32'd0);
`else
    check_eq("and_err_vec", 32'(err_vec1), 32'h0);
    check_eq("and_err_cnt", 32'(err_cnt1), 32'd0);
    check_eq("and_pass", 32'(pass1), 32'd1);
`endif

    // SETTLE=3 instance: four cycles per row.
    sweep(1, 3, 1'b0, done_at, n_done, busy_cycles, stim_bad);
    check_eq("s3_done_at", done_at, 17);
    check_eq("s3_n_done", n_done, 1);
    check_eq("s3_busy_cycles", busy_cycles, 16);
    check_eq("s3_stim_seq", stim_bad, 0);
    check_eq("s3_pass", 32'(pass2), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 SHALL have parameter N, default 2, number of stimulus inputs (1..4).
REQ-002 SHALL have parameter SETTLE, default 1, drive cycles per row before sampling (1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port start, input, 1, request one full truth-table sweep.
REQ-006 SHALL have port a_in, input, 1, output of gate implementation A (gate-primitive form).
REQ-007 SHALL have port b_in, input, 1, output of gate implementation B (expression form).
REQ-008 SHALL have port stim, output, N, stimulus to both implementations; stim[N-1] is the first operand (x), stim[0] is the last operand (y).
REQ-009 SHALL have port busy, output, 1, sweep in progress.
REQ-010 SHALL have port done, output, 1, one-cycle pulse at sweep end.
REQ-011 SHALL have port pass, output, 1, last sweep had zero mismatches.
REQ-012 SHALL have port err_vec, output, 2**N, bit r set when row r mismatched.
REQ-013 SHALL have port err_cnt, output, N+1, number of mismatched rows.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, SAMPLE, FIN.
- IDLE: start=1 -> DRIVE; clear stim, err_vec, err_cnt, pass.
- DRIVE: hold stim for SETTLE cycles -> SAMPLE.
- SAMPLE: compare once; stim == all-ones -> FIN; else stim+1 -> DRIVE.
- FIN: done=1 for exactly one cycle -> IDLE.
REQ-015 SHALL flag row r as mismatched when a_in != b_in during the SAMPLE cycle with stim == r.
REQ-016 SHALL visit rows in ascending binary order 0 .. 2**N-1 (N=2: 00, 01, 10, 11); no wrap-around past all-ones.
REQ-017 SHALL saturate err_cnt at 2**N; no modulo wrap.
REQ-018 SHALL assert done in cycle t+1+2**N*(SETTLE+1) when start is sampled in cycle t (N=2, SETTLE=1: t+9).
REQ-019 SHALL assert busy in DRIVE and SAMPLE only.
REQ-020 SHALL ignore start while busy or in FIN; a new sweep starts only from IDLE.
REQ-021 SHALL set pass in FIN iff err_cnt == 0, and hold pass, err_vec and err_cnt until the next accepted start.
REQ-022 SHALL keep stim stable for the whole SETTLE+1 cycle window of each row.

Reset
REQ-023 SHALL, when rst=1, enter IDLE next edge: stim=0, busy=0, done=0, pass=0, err_vec=0, err_cnt=0.
REQ-024 SHALL let rst override start in the same cycle.
REQ-025 SHALL abort a sweep on reset mid-operation, with no done pulse and no partial results retained.

Configuration
REQ-026 SHALL use macro TT_GOLDEN_EN.
- Defined: row also mismatches when a_in != |stim (golden disjunction); err_vec/err_cnt count a row once even if both checks fail.
- Undefined: only the a_in vs b_in comparison exists; no golden logic is synthesised.

Structure
REQ-027 SHALL place the FSM state typedef, default N/SETTLE constants and the row-count function in shared package tt_pkg.
REQ-028 SHALL implement the per-row settle counter as sub-module tt_settle_timer (load, count-down, expire pulse).

Verification
REQ-029 SHALL cover: N=2, SETTLE=1, b_in=a_in=|stim, start pulse at t -> done at t+9, pass=1, err_vec=0000, err_cnt=0.
REQ-030 SHALL cover: b_in forced to 0 when stim=2'b10 -> err_vec=0100, err_cnt=1, pass=0.
REQ-031 SHALL cover: start re-asserted during busy -> ignored, single done, stim sequence unchanged.
REQ-032 SHALL cover: rst=1 while stim=2'b01 -> next cycle stim=0, busy=0, no done; a fresh start then completes normally.
REQ-033 SHALL cover: TT_GOLDEN_EN defined, a_in=b_in=&stim (AND) -> err_vec=0110, err_cnt=2; undefined -> pass=1.
REQ-034 SHALL cover: N=2, SETTLE=3, start at t -> done at t+17, each stim value held 4 cycles.
